// File: rtl/cpu_isa_pkg.sv
// Instruction-class and hold-length definitions shared by the sequencer and anything
// else that needs to know how long the CU spends on each instruction class.
package cpu_isa_pkg;

  localparam int CLS_MSB = 19;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [2:0] HOLD_STD   = 3'd3;
  localparam logic [2:0] HOLD_LOAD  = 3'd4;
  localparam logic [2:0] HOLD_STORE = 3'd3;
  localparam logic [2:0] WAKE_EXTRA = 3'd1;

  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} seq_state_e;

  function automatic logic [2:0] hold_of(input logic [1:0] cls);
    case (cls)
      CLS_STD:   hold_of = HOLD_STD;
      CLS_LOAD:  hold_of = HOLD_LOAD;
      CLS_STORE: hold_of = HOLD_STORE;
      default:   hold_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Small program store: synchronous write, combinational read.
// Contents deliberately have no reset so a program survives a sequencer reset.
module prog_mem #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 4
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [ADDR_BITS-1:0]   i_waddr,
  input  logic [INSTR_WIDTH-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0]   i_raddr,
  output logic [INSTR_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds simple_cpu one instruction at a time, holding each word for exactly as many
// cycles as the CU needs for its class, since the CU gives no acknowledge.
module instr_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [PROG_ADDR_BITS-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]    load_data,
  input  logic                      start,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      issue,
  output logic                      busy,
  output logic                      done
);

  seq_state_e                r_state;
  logic [2:0]                r_hold;
  logic [INSTR_WIDTH-1:0]    r_instr;
  logic [PROG_ADDR_BITS-1:0] r_pc;
  logic                      r_issue;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_we;
  logic [PROG_ADDR_BITS-1:0] w_raddr;
  logic [INSTR_WIDTH-1:0]    w_rdata;
  logic [1:0]                w_cls;
  logic                      w_last;

  // One read port: IDLE only ever looks at word 0, ISSUE only at the next word.
  assign w_we    = load_en && (r_state == IDLE);
  assign w_raddr = (r_state == ISSUE) ? r_pc + 1'b1 : '0;
  assign w_cls   = w_rdata[CLS_MSB -: 2];
  assign w_last  = (r_pc == '1);

  prog_mem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_BITS   (PROG_ADDR_BITS)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_instr <= '0;
      r_pc    <= '0;
      r_issue <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cls != CLS_HALT) begin
              // First word carries an extra cycle for the CU leaving RESET.
              r_instr <= w_rdata;
              r_pc    <= '0;
              r_hold  <= hold_of(w_cls) + WAKE_EXTRA;
              r_issue <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_state <= FINISH;
            end
          end
        end
        ISSUE: begin
          if (r_hold > 3'd1) begin
            r_hold <= r_hold - 3'd1;
          end else if (w_cls != CLS_HALT && !w_last) begin
            r_instr <= w_rdata;
            r_pc    <= r_pc + 1'b1;
            r_hold  <= hold_of(w_cls);
            r_issue <= 1'b1;
          end else begin
            // Halt word or top of memory: the program never wraps to address 0.
            r_instr <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign issue       = r_issue;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues expected issue/done events,
// a monitor pops them on each DUT event and checks word, pc, hold length and stability.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [19:0] load_data = '0;
  logic        start = 1'b0;
  logic [19:0] instruction;
  logic [3:0]  pc;
  logic        issue;
  logic        busy;
  logic        done;

  instr_sequencer #(
    .INSTR_WIDTH    (20),
    .PROG_ADDR_BITS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .instruction (instruction),
    .pc          (pc),
    .issue       (issue),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [19:0] instr;
    logic [3:0]  pc;
    int          len;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_issue(input logic [19:0] ins, input logic [3:0] p, input int len);
    exp_t e;
    e.is_done = 1'b0; e.instr = ins; e.pc = p; e.len = len;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.instr = '0; e.pc = '0; e.len = 0;
    q.push_back(e);
  endtask

  // Monitor: hold length of a word is measured at the event that ends it.
  int          cyc = 0;
  int          prev_cyc = 0;
  int          prev_len = 0;
  int          bad_hold = 0;
  bit          have_prev = 1'b0;
  logic [19:0] prev_instr = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_prev = 1'b0;
        bad_hold  = 0;
      end else begin
        cyc++;
        if (issue || done) begin
          if (have_prev) begin
            chk("hold_len", cyc - prev_cyc, prev_len);
            chk("hold_stable", bad_hold, 0);
            have_prev = 1'b0;
          end
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got issue=%0b done=%0b pc=%0d, expected no event",
                     issue, done, pc);
          end else begin
            e = q.pop_front();
            chk("event_kind", {30'd0, issue, done}, e.is_done ? 32'd1 : 32'd2);
            if (e.is_done) begin
              chk("done_instr", instruction, 0);
              chk("done_busy", busy, 0);
            end else begin
              chk("issue_instr", instruction, e.instr);
              chk("issue_pc", pc, e.pc);
              chk("issue_busy", busy, 1);
              have_prev  = 1'b1;
              prev_cyc   = cyc;
              prev_len   = e.len;
              prev_instr = e.instr;
              bad_hold   = 0;
            end
          end
        end else if (have_prev && instruction !== prev_instr) begin
          bad_hold++;
        end
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [19:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    for (int i = 0; i < max && q.size() != 0; i++) @(negedge clk);
    chk(name, q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic load_mixed();
    load(4'd0, 20'h4_1200);
    load(4'd1, 20'h8_4010);
    load(4'd2, 20'hC_4020);
    load(4'd3, 20'h0_0000);
  endtask

  task automatic exp_mixed();
    push_issue(20'h4_1200, 4'd0, 4);
    push_issue(20'h8_4010, 4'd1, 4);
    push_issue(20'hC_4020, 4'd2, 3);
    push_done();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_instr"}, instruction, 0);
    chk({tag, "_pc"},    pc, 0);
    chk({tag, "_issue"}, issue, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
  endtask

  initial begin
    bit found;
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b1;

    // Single std_op: wake cycle makes it 4 cycles long.
    load(4'd0, 20'h4_1200);
    load(4'd1, 20'h0_0000);
    push_issue(20'h4_1200, 4'd0, 4);
    push_done();
    run_start();
    drain("single_drain", 30);

    // Mixed std / loadR / storeR then halt.
    load_mixed();
    exp_mixed();
    run_start();
    drain("mixed_drain", 40);

    // Empty program.
    load(4'd0, 20'h0_0000);
    push_done();
    run_start();
    chk("empty_busy", busy, 0);
    drain("empty_drain", 20);

    // Full memory of std_ops, no halt: stops at pc 15 without wrapping.
    for (int i = 0; i < 16; i++) load(4'(i), 20'h4_0000 + 20'(i));
    for (int i = 0; i < 16; i++) push_issue(20'h4_0000 + 20'(i), 4'(i), (i == 0) ? 4 : 3);
    push_done();
    run_start();
    drain("full_drain", 100);

    // Writes and start mid-run must be ignored; rerun proves memory unchanged.
    load_mixed();
    exp_mixed();
    run_start();
    repeat (2) @(negedge clk);
    load_en = 1'b1; load_addr = 4'd1; load_data = 20'hF_FFFF;
    @(negedge clk);
    load_addr = 4'd0; load_data = 20'h0_0000; start = 1'b1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    drain("ignored_drain", 40);
    exp_mixed();
    run_start();
    drain("ignored_rerun_drain", 40);

    // Reset during the loadR hold, then rerun the retained program.
    exp_mixed();
    run_start();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (issue && pc == 4'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_loadR", found, 1);
    #2 rst = 1'b0;
    #1 chk_outputs_zero("midreset");
    q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_outputs_zero("post_release");
    exp_mixed();
    run_start();
    drain("rerun_drain", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
